mac_stream_feeder: RTL and testbench

- Transmit-side companion to piped_mac: generates the SD_AXIS stream that piped_mac consumes.
- Per command: emits one bias beat, then cmd_len packed int8 weight/activation pairs read from two 1-cycle-latency on-chip memories, with TLAST on the final beat.
- Sits between the layer controller, which issues commands, and piped_mac's input port.

---
 rtl/mac_stream_feeder_pkg.sv | 12 +
 rtl/mac_stream_feeder_if.sv | 20 ++
 rtl/mac_stream_feeder_beat_fifo.sv | 53 +++++
 rtl/mac_stream_feeder.sv | 152 +++++++++++++++
 tb/tb_mac_stream_feeder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_stream_feeder_pkg.sv
// Shared types for the piped_mac input stream generator.
package mac_stream_pkg;
    localparam int BEAT_W  = 16;
    localparam int TUSER_W = 32;

    typedef enum logic [1:0] {IDLE, BIAS, STREAM} state_t;

    typedef struct packed {
        logic [BEAT_W-1:0] data;
        logic              last;
    } beat_t;
endpackage

// File: rtl/mac_stream_feeder_if.sv
// Outbound AXI-Stream bundle toward piped_mac.
interface mac_stream_feeder_if;
    import mac_stream_pkg::*;

    logic               MO_AXIS_TVALID;
    logic               MO_AXIS_TREADY;
    logic [BEAT_W-1:0]  MO_AXIS_TDATA;
    logic               MO_AXIS_TLAST;
    logic [TUSER_W-1:0] MO_AXIS_TUSER;

    modport master (
        output MO_AXIS_TVALID, MO_AXIS_TDATA, MO_AXIS_TLAST, MO_AXIS_TUSER,
        input  MO_AXIS_TREADY
    );

    modport slave (
        input  MO_AXIS_TVALID, MO_AXIS_TDATA, MO_AXIS_TLAST, MO_AXIS_TUSER,
        output MO_AXIS_TREADY
    );
endinterface

// File: rtl/mac_stream_feeder_beat_fifo.sv
// Small synchronous FIFO of pair beats; absorbs memory read latency under stalls.
module mac_beat_fifo
    import mac_stream_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  beat_t            i_din,
    input  logic             i_pop,
    output beat_t            o_dout,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full
);
    beat_t            r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage, pointers and occupancy; reset drops any buffered beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= ptr_next(r_wr_ptr);
            end
            if (i_pop) r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
endmodule

// File: rtl/mac_stream_feeder.sv
// Per command: one bias beat, then cmd_len {weight,activation} beats fetched
// from two 1-cycle memories, TLAST on the final beat.
module mac_stream_feeder
    import mac_stream_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [BEAT_W-1:0]   cmd_bias,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [ADDR_W-1:0]   cmd_w_base,
    input  logic [ADDR_W-1:0]   cmd_a_base,
    input  logic [TUSER_W-1:0]  cmd_tuser,
    output logic                w_rd_en,
    output logic [ADDR_W-1:0]   w_rd_addr,
    input  logic [7:0]          w_rd_data,
    output logic                a_rd_en,
    output logic [ADDR_W-1:0]   a_rd_addr,
    input  logic [7:0]          a_rd_data,
    mac_stream_feeder_if.master mo_axis,
    output logic                done
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    state_t             r_state;
    logic               r_alive;
    logic [BEAT_W-1:0]  r_bias;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_rd_cnt;
    logic [ADDR_W-1:0]  r_w_base;
    logic [ADDR_W-1:0]  r_a_base;
    logic [TUSER_W-1:0] r_tuser;
    logic               r_inflight;
    logic               r_inflight_last;

    beat_t              w_rx_beat;
    beat_t              w_head;
    beat_t              w_out;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W:0]     w_occ;
    logic               w_empty, w_full;
    logic               w_tvalid, w_hs, w_push, w_pop, w_rd, w_cmd_hs, w_active;

    // Memory data is live in the cycle after the read strobe.
    assign w_rx_beat = {w_rd_data, a_rd_data, r_inflight_last};

    // Output beat select: bias first, then FIFO head, else the returning read
    // directly so an unstalled stream has no bubbles.
    always_comb begin
        w_tvalid = 1'b0;
        w_out    = '0;
        case (r_state)
            BIAS: begin
                w_tvalid = 1'b1;
                w_out    = {r_bias, (r_len == '0)};
            end
            STREAM: begin
                if (!w_empty) begin
                    w_tvalid = 1'b1;
                    w_out    = w_head;
                end else if (r_inflight) begin
                    w_tvalid = 1'b1;
                    w_out    = w_rx_beat;
                end
            end
            default: ;
        endcase
    end

    assign mo_axis.MO_AXIS_TVALID = w_tvalid;
    assign mo_axis.MO_AXIS_TDATA  = w_out.data;
    assign mo_axis.MO_AXIS_TLAST  = w_out.last;
    assign mo_axis.MO_AXIS_TUSER  = w_tvalid ? r_tuser : '0;

    assign w_hs      = w_tvalid && mo_axis.MO_AXIS_TREADY;
    assign done      = w_hs && w_out.last;
    assign cmd_ready = r_alive && (r_state == IDLE);
    assign w_cmd_hs  = cmd_valid && cmd_ready;
    assign w_active  = (r_state == BIAS) || (r_state == STREAM);

    // A returning read bypasses the FIFO only when it is consumed on arrival.
    assign w_pop  = (r_state == STREAM) && w_hs && !w_empty;
    assign w_push = r_inflight && !((r_state == STREAM) && w_hs && w_empty) && !w_full;

    // Count the read in flight as occupied space so a stall can never overflow.
    assign w_occ = {1'b0, w_count} + (CNT_W + 1)'(r_inflight);
    assign w_rd  = w_active && (r_rd_cnt < r_len) && (w_occ < (CNT_W + 1)'(FIFO_DEPTH));

    assign w_rd_en   = w_rd;
    assign a_rd_en   = w_rd;
    assign w_rd_addr = w_rd ? r_w_base + ADDR_W'(r_rd_cnt) : '0;
    assign a_rd_addr = w_rd ? r_a_base + ADDR_W'(r_rd_cnt) : '0;

    // Command sequencing: accept, bias beat, pair beats until TLAST handshake.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state  <= IDLE;
            r_alive  <= 1'b0;
            r_bias   <= '0;
            r_len    <= '0;
            r_w_base <= '0;
            r_a_base <= '0;
            r_tuser  <= '0;
        end else begin
            r_alive <= 1'b1;
            case (r_state)
                IDLE: if (w_cmd_hs) begin
                    r_bias   <= cmd_bias;
                    r_len    <= cmd_len;
                    r_w_base <= cmd_w_base;
                    r_a_base <= cmd_a_base;
                    r_tuser  <= cmd_tuser;
                    r_state  <= BIAS;
                end
                BIAS:    if (w_hs) r_state <= (r_len == '0) ? IDLE : STREAM;
                STREAM:  if (done) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Read issue bookkeeping; the in-flight flag marks data arriving next cycle.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rd_cnt        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_rd;
            r_inflight_last <= w_rd && (r_rd_cnt == r_len - LEN_W'(1));
            if (w_cmd_hs)  r_rd_cnt <= '0;
            else if (w_rd) r_rd_cnt <= r_rd_cnt + LEN_W'(1);
        end
    end

    mac_beat_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .i_push  (w_push),
        .i_din   (w_rx_beat),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );
endmodule

// File: tb/tb_mac_stream_feeder.sv
// Scoreboard bench: stimulus queues expected beats/addresses, a monitor
// process compares them at every handshake / read strobe.
module tb_mac_stream_feeder;
    import mac_stream_pkg::*;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
        logic [31:0] u;
    } exp_t;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        cmd_valid, cmd_ready;
    logic [15:0] cmd_bias, cmd_len;
    logic [11:0] cmd_w_base, cmd_a_base;
    logic [31:0] cmd_tuser;
    logic        w_rd_en, a_rd_en, done;
    logic [11:0] w_rd_addr, a_rd_addr;
    logic [7:0]  w_rd_data, a_rd_data;
    logic [7:0]  wmem [4096];
    logic [7:0]  amem [4096];

    exp_t        exp_q [$];
    logic [23:0] addr_q [$];
    int          n_chk = 0, n_pass = 0, n_rd = 0, n_done = 0, cyc = 0;
    int          acc = 0, last_mac = 0, done_cyc = 0, last_gap = 0;
    bit          first = 1'b1, prev_stall = 1'b0, stall_en = 1'b0;
    logic [15:0] pd;
    logic        pl;
    logic [31:0] pu;
    exp_t        me;
    logic [23:0] ma;
    bit          stall_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int          pi = 0;

    mac_stream_feeder_if axis ();

    mac_stream_feeder #(.ADDR_W(12), .LEN_W(16), .FIFO_DEPTH(2)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_bias(cmd_bias),
        .cmd_len(cmd_len), .cmd_w_base(cmd_w_base), .cmd_a_base(cmd_a_base),
        .cmd_tuser(cmd_tuser),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
        .mo_axis(axis), .done(done)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    // 1-cycle-latency memories
    always @(posedge ACLK) begin
        if (w_rd_en) w_rd_data <= wmem[w_rd_addr];
        if (a_rd_en) a_rd_data <= amem[a_rd_addr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic ex(input logic [15:0] d, input logic l, input logic [31:0] u);
        exp_q.push_back('{d: d, l: l, u: u});
    endtask

    task automatic send_cmd(input logic [15:0] b, input logic [15:0] len,
                            input logic [11:0] wb, input logic [11:0] ab, input logic [31:0] tu);
        bit ok = 1'b0;
        for (int i = 0; i < int'(len); i++) addr_q.push_back({wb + 12'(i), ab + 12'(i)});
        cmd_bias = b; cmd_len = len; cmd_w_base = wb; cmd_a_base = ab; cmd_tuser = tu;
        cmd_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge ACLK);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        @(posedge ACLK); #1;
        cmd_valid = 1'b0;
        chk("cmd_accept", ok, 1);
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge ACLK);
            if (exp_q.size() == 0 && addr_q.size() == 0) begin ok = 1'b1; break; end
        end
        chk("drain", ok, 1);
        repeat (2) @(posedge ACLK);
        #1;
    endtask

    // Ready generator: always high, or a fixed stall pattern when enabled
    initial begin
        axis.MO_AXIS_TREADY = 1'b1;
        forever begin
            @(posedge ACLK); #1;
            if (stall_en) begin
                axis.MO_AXIS_TREADY = stall_pat[pi];
                pi = (pi + 1) % 6;
            end else begin
                axis.MO_AXIS_TREADY = 1'b1;
                pi = 0;
            end
        end
    end

    // Monitor: beat order/content, hold-while-stalled, done, read addresses
    initial begin
        forever begin
            @(negedge ACLK);
            if (ARESETN !== 1'b1) begin
                prev_stall = 1'b0;
                first      = 1'b1;
            end else begin
                if (prev_stall)
                    chk("hold", {axis.MO_AXIS_TVALID, axis.MO_AXIS_TDATA, axis.MO_AXIS_TLAST, axis.MO_AXIS_TUSER},
                        {1'b1, pd, pl, pu});
                prev_stall = axis.MO_AXIS_TVALID && !axis.MO_AXIS_TREADY;
                pd = axis.MO_AXIS_TDATA; pl = axis.MO_AXIS_TLAST; pu = axis.MO_AXIS_TUSER;
                if (axis.MO_AXIS_TVALID && axis.MO_AXIS_TREADY) begin
                    chk("beat_avail", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        me = exp_q.pop_front();
                        chk("beat", {axis.MO_AXIS_TDATA, axis.MO_AXIS_TLAST, axis.MO_AXIS_TUSER}, me);
                        chk("done_on_last", done, me.l);
                    end
                    if (first) begin
                        acc      = int'($signed(axis.MO_AXIS_TDATA));
                        last_gap = cyc - done_cyc;
                    end else begin
                        acc = acc + int'($signed(axis.MO_AXIS_TDATA[15:8])) * int'($signed(axis.MO_AXIS_TDATA[7:0]));
                    end
                    first = axis.MO_AXIS_TLAST;
                    if (axis.MO_AXIS_TLAST) last_mac = acc;
                    if (done) begin n_done++; done_cyc = cyc; end
                end else begin
                    chk("done_idle", done, 0);
                end
                if (w_rd_en || a_rd_en) begin
                    n_rd++;
                    chk("rd_en_pair", {w_rd_en, a_rd_en}, 2'b11);
                    chk("rd_avail", addr_q.size() != 0, 1);
                    if (addr_q.size() != 0) begin
                        ma = addr_q.pop_front();
                        chk("rd_addr", {w_rd_addr, a_rd_addr}, ma);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nrd0, d0;
        cmd_valid = 1'b0; cmd_bias = '0; cmd_len = '0;
        cmd_w_base = '0; cmd_a_base = '0; cmd_tuser = '0;
        w_rd_data = '0; a_rd_data = '0;
        for (int i = 0; i < 4096; i++) begin wmem[i] = '0; amem[i] = '0; end
        ARESETN = 1'b1;
        #2 ARESETN = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        chk("rst_ctl", {cmd_ready, axis.MO_AXIS_TVALID, axis.MO_AXIS_TLAST, w_rd_en, a_rd_en, done}, 6'b0);
        chk("rst_data", {axis.MO_AXIS_TDATA, axis.MO_AXIS_TUSER}, 48'h0);
        chk("rst_addr", {w_rd_addr, a_rd_addr}, 24'h0);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        chk("ready_after_rst", cmd_ready, 1);

        // T1: bias -600, W={-50,5}, A={38,2}, ready high
        wmem[12'h100] = 8'hCE; wmem[12'h101] = 8'h05;
        amem[12'h200] = 8'h26; amem[12'h201] = 8'h02;
        ex(16'hFDA8, 0, 32'h11); ex(16'hCE26, 0, 32'h11); ex(16'h0502, 1, 32'h11);
        send_cmd(16'hFDA8, 16'd2, 12'h100, 12'h200, 32'h11);
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            chk("t1_beat_cycle", {axis.MO_AXIS_TVALID, axis.MO_AXIS_TREADY}, 2'b11);
        end
        @(negedge ACLK);
        chk("t1_idle_after", axis.MO_AXIS_TVALID, 0);
        wait_drain();
        chk("t1_mac", last_mac, -2490);

        // T2: same stream with ready toggling
        stall_en = 1'b1;
        ex(16'hFDA8, 0, 32'h22); ex(16'hCE26, 0, 32'h22); ex(16'h0502, 1, 32'h22);
        send_cmd(16'hFDA8, 16'd2, 12'h100, 12'h200, 32'h22);
        wait_drain();
        stall_en = 1'b0;
        chk("t2_mac", last_mac, -2490);

        // T3: len 0, bias 5000
        nrd0 = n_rd; d0 = n_done;
        ex(16'h1388, 1, 32'h33);
        send_cmd(16'h1388, 16'd0, 12'h000, 12'h000, 32'h33);
        wait_drain();
        chk("t3_no_reads", n_rd - nrd0, 0);
        chk("t3_done", n_done - d0, 1);

        // T4: weight address wrap, TUSER 99 on every beat
        wmem[12'hFFE] = 8'h11; wmem[12'hFFF] = 8'h22; wmem[12'h000] = 8'h33;
        amem[12'h000] = 8'h44; amem[12'h001] = 8'h55; amem[12'h002] = 8'h66;
        ex(16'h0007, 0, 32'd99); ex(16'h1144, 0, 32'd99);
        ex(16'h2255, 0, 32'd99); ex(16'h3366, 1, 32'd99);
        send_cmd(16'h0007, 16'd3, 12'hFFE, 12'h000, 32'd99);
        wait_drain();

        // T5: reset while pair 1 of a len=4 command is on the bus
        for (int i = 0; i < 4; i++) begin
            wmem[12'h300 + 12'(i)] = 8'(i + 1);
            amem[12'h400 + 12'(i)] = 8'(i + 5);
        end
        ex(16'h0064, 0, 32'd7); ex(16'h0105, 0, 32'd7); ex(16'h0206, 0, 32'd7);
        send_cmd(16'h0064, 16'd4, 12'h300, 12'h400, 32'd7);
        @(posedge ACLK); @(posedge ACLK); #1;
        chk("t5_pair1_shown", {axis.MO_AXIS_TVALID, axis.MO_AXIS_TDATA}, {1'b1, 16'h0206});
        ARESETN = 1'b0;
        #1;
        chk("t5_rst_ctl", {cmd_ready, axis.MO_AXIS_TVALID, axis.MO_AXIS_TLAST, w_rd_en, a_rd_en, done}, 6'b0);
        chk("t5_rst_data", {axis.MO_AXIS_TDATA, axis.MO_AXIS_TUSER}, 48'h0);
        exp_q.delete();
        addr_q.delete();
        @(posedge ACLK); @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        wmem[12'h500] = 8'h86; wmem[12'h501] = 8'h77; wmem[12'h502] = 8'h95;
        amem[12'h600] = 8'hF1; amem[12'h601] = 8'hFD; amem[12'h602] = 8'h0D;
        ex(16'hFBFC, 0, 32'd5); ex(16'h86F1, 0, 32'd5);
        ex(16'h77FD, 0, 32'd5); ex(16'h950D, 1, 32'd5);
        send_cmd(16'hFBFC, 16'd3, 12'h500, 12'h600, 32'd5);
        wait_drain();

        // T6: back-to-back commands with cmd_valid held
        d0 = n_done;
        wmem[12'h700] = 8'h7A; amem[12'h700] = 8'h01;
        wmem[12'h710] = 8'h10; wmem[12'h711] = 8'h20;
        amem[12'h710] = 8'h01; amem[12'h711] = 8'h02;
        ex(16'h0123, 0, 32'hAAAA0001); ex(16'h7A01, 1, 32'hAAAA0001);
        ex(16'h0456, 0, 32'hBBBB0002); ex(16'h1001, 0, 32'hBBBB0002);
        ex(16'h2002, 1, 32'hBBBB0002);
        send_cmd(16'h0123, 16'd1, 12'h700, 12'h700, 32'hAAAA0001);
        send_cmd(16'h0456, 16'd2, 12'h710, 12'h710, 32'hBBBB0002);
        wait_drain();
        chk("t6_gap_le2", last_gap <= 2, 1);
        chk("t6_done_count", n_done - d0, 2);

        chk("queues_empty", exp_q.size() + addr_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
